// File: rtl/br_pkg.sv
// Shared definitions for the branch resolver: funct3 encodings, 2-bit counter
// states, the BTB entry layout and the branch-condition helpers.
package br_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Widest tag occurs with two entries; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 29;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    localparam btb_entry_t BTB_RESET = '{valid: 1'b0, tag: '0, target: 32'd0, ctr: WNT};

    function automatic logic br_taken(input logic [2:0] f3, input logic less, input logic equal);
        logic t;
        case (f3)
            F3_BEQ:           t = equal;
            F3_BNE:           t = ~equal;
            F3_BLT, F3_BLTU:  t = less;
            F3_BGE, F3_BGEU:  t = ~less;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b010, 3'b011: ok = 1'b0;
            default:        ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_ctr2
    import br_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Step toward the outcome, clamping at the strong states.
    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            SNT:     ctr_o = taken_i ? WNT : SNT;
            WNT:     ctr_o = taken_i ? WT  : SNT;
            WT:      ctr_o = taken_i ? ST  : WNT;
            ST:      ctr_o = taken_i ? ST  : WT;
            default: ctr_o = WNT;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolver with a direct-mapped BTB: IF-stage prediction, EX-stage
// taken decision, same-cycle redirect/flush and branch/mispredict counters.
module branch_ctrl
    import br_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jmp,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    input  logic        i_stall,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_misp_cnt
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    btb_entry_t btb_q [BTB_ENTRIES];
    btb_entry_t rd_entry_s;
    btb_entry_t ex_entry_s;
    btb_entry_t upd_entry_d;
    logic       upd_en_d;

    logic [IDX_W-1:0]     if_idx_s;
    logic [IDX_W-1:0]     ex_idx_s;
    logic [TAG_MAX_W-1:0] if_tag_s;
    logic [TAG_MAX_W-1:0] ex_tag_s;
    logic                 if_hit_s;
    logic                 ex_hit_s;
    logic                 act_s;
    logic                 legal_s;
    logic                 taken_s;
    logic [1:0]           ctr_next_s;
    logic                 redirect_s;
    logic [31:0]          redirect_pc_s;
    logic [31:0]          br_cnt_q, br_cnt_d;
    logic [31:0]          misp_cnt_q, misp_cnt_d;
    logic                 unused_s;

    assign if_idx_s = i_if_pc[IDX_W+1:2];
    assign ex_idx_s = i_ex_pc[IDX_W+1:2];
    assign if_tag_s = TAG_MAX_W'(i_if_pc[31:IDX_W+2]);
    assign ex_tag_s = TAG_MAX_W'(i_ex_pc[31:IDX_W+2]);
    assign unused_s = ^{i_if_pc[1:0], TAG_W[0]};

    assign act_s   = i_ex_valid & (i_ex_is_br | i_ex_is_jmp) & ~i_stall & ~i_reset;
    assign legal_s = i_ex_is_jmp | f3_legal(i_ex_funct3);
    assign taken_s = i_ex_is_jmp | br_taken(i_ex_funct3, i_br_less, i_br_equal);
    assign o_br_un = i_ex_funct3[1];

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (ex_entry_s.ctr),
        .taken_i (taken_s),
        .ctr_o   (ctr_next_s)
    );

    // IF lookup reads the registered array, so same-cycle writes are not visible.
    always_comb begin
        rd_entry_s    = btb_q[if_idx_s];
        if_hit_s      = rd_entry_s.valid && (rd_entry_s.tag == if_tag_s);
        o_pred_taken  = if_hit_s & rd_entry_s.ctr[1] & ~i_reset;
        o_pred_target = if_hit_s ? rd_entry_s.target : 32'd0;
    end

    // Mispredict detection against the prediction carried with the instruction.
    always_comb begin
        redirect_s    = 1'b0;
        redirect_pc_s = i_ex_target;
        if (act_s) begin
            if (taken_s) begin
                redirect_s = ~i_ex_pred_taken | (i_ex_pred_target != i_ex_target);
            end else begin
                redirect_s    = i_ex_pred_taken;
                redirect_pc_s = i_ex_pc + 32'd4;
            end
        end else begin
            redirect_s = 1'b0;
        end
    end

    assign o_redirect    = redirect_s;
    assign o_flush       = redirect_s;
    assign o_redirect_pc = redirect_pc_s;

    // BTB write selection: jumps pin strongly taken, misses allocate only when taken.
    always_comb begin
        ex_entry_s  = btb_q[ex_idx_s];
        ex_hit_s    = ex_entry_s.valid && (ex_entry_s.tag == ex_tag_s);
        upd_en_d    = 1'b0;
        upd_entry_d = ex_entry_s;
        if (act_s && legal_s) begin
            if (i_ex_is_jmp) begin
                upd_en_d    = 1'b1;
                upd_entry_d = '{valid: 1'b1, tag: ex_tag_s, target: i_ex_target, ctr: ST};
            end else if (ex_hit_s) begin
                upd_en_d        = 1'b1;
                upd_entry_d.ctr = ctr_next_s;
                if (taken_s) begin
                    upd_entry_d.target = i_ex_target;
                end else begin
                    upd_entry_d.target = ex_entry_s.target;
                end
            end else if (taken_s) begin
                upd_en_d    = 1'b1;
                upd_entry_d = '{valid: 1'b1, tag: ex_tag_s, target: i_ex_target, ctr: WT};
            end else begin
                upd_en_d = 1'b0;
            end
        end else begin
            upd_en_d = 1'b0;
        end
    end

    // Statistics next-state.
    always_comb begin
        br_cnt_d   = act_s ? br_cnt_q + 32'd1 : br_cnt_q;
        misp_cnt_d = redirect_s ? misp_cnt_q + 32'd1 : misp_cnt_q;
    end

    // BTB array; reset invalidates every entry and wins over any update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= BTB_RESET;
            end
        end else if (upd_en_d) begin
            btb_q[ex_idx_s] <= upd_entry_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            br_cnt_q   <= 32'd0;
            misp_cnt_q <= 32'd0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign o_br_cnt   = br_cnt_q;
    assign o_misp_cnt = misp_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_br, ex_is_jmp;
    logic [2:0]  ex_f3;
    logic [31:0] ex_pc, ex_target, ex_ptgt;
    logic        ex_ptaken;
    logic        br_un, br_less, br_equal, stall;
    logic        redirect, flush;
    logic [31:0] redirect_pc, br_cnt, misp_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state: one slot per BTB entry, counter as an integer 0..3.
    bit          mv   [16];
    logic [31:0] mtag [16];
    logic [31:0] mtgt [16];
    int          mctr [16];
    logic [31:0] mbr, mmisp;

    always #5 clk = ~clk;

    branch_ctrl #(.BTB_ENTRIES(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_if_pc(if_pc),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_is_jmp(ex_is_jmp),
        .i_ex_funct3(ex_f3), .i_ex_pc(ex_pc), .i_ex_target(ex_target),
        .i_ex_pred_taken(ex_ptaken), .i_ex_pred_target(ex_ptgt),
        .o_br_un(br_un), .i_br_less(br_less), .i_br_equal(br_equal),
        .i_stall(stall), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
        .o_flush(flush), .o_br_cnt(br_cnt), .o_misp_cnt(misp_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return (pc / 4) % 16;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return mv[m_idx(pc)] && (mtag[m_idx(pc)] == pc / 64);
    endfunction

    function automatic bit m_taken();
        if (ex_is_jmp) return 1'b1;
        case (int'(ex_f3))
            0:       return ex_equal_b();
            1:       return !ex_equal_b();
            4, 6:    return br_less;
            5, 7:    return !br_less;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ex_equal_b();
        return br_equal;
    endfunction

    function automatic bit m_active();
        return !rst && !stall && ex_valid && (ex_is_br || ex_is_jmp);
    endfunction

    function automatic bit m_redirect();
        if (!m_active()) return 1'b0;
        if (m_taken()) return !ex_ptaken || (ex_ptgt != ex_target);
        return ex_ptaken;
    endfunction

    task automatic compare_all();
        bit hit = m_hit(if_pc);
        bit rd  = m_redirect();
        chk("pred_taken",  pred_taken, (!rst && hit && mctr[m_idx(if_pc)] >= 2));
        chk("pred_target", pred_target, hit ? mtgt[m_idx(if_pc)] : 32'd0);
        chk("br_un",       br_un, (int'(ex_f3) == 2 || int'(ex_f3) == 3 || int'(ex_f3) >= 6));
        chk("redirect",    redirect, rd);
        chk("flush",       flush, rd);
        if (rd) chk("redirect_pc", redirect_pc, m_taken() ? ex_target : ex_pc + 32'd4);
        chk("br_cnt",      br_cnt, mbr);
        chk("misp_cnt",    misp_cnt, mmisp);
    endtask

    task automatic m_update();
        int  i;
        bit  tk;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                mv[k] = 1'b0; mctr[k] = 1;
            end
            mbr = 0; mmisp = 0;
        end else if (m_active()) begin
            if (m_redirect()) mmisp = mmisp + 1;
            mbr = mbr + 1;
            i  = m_idx(ex_pc);
            tk = m_taken();
            if (ex_is_jmp || !(int'(ex_f3) == 2 || int'(ex_f3) == 3)) begin
                if (ex_is_jmp || (!m_hit(ex_pc) && tk)) begin
                    mv[i] = 1'b1; mtag[i] = ex_pc / 64; mtgt[i] = ex_target;
                    mctr[i] = ex_is_jmp ? 3 : 2;
                end else if (m_hit(ex_pc)) begin
                    mctr[i] = tk ? ((mctr[i] == 3) ? 3 : mctr[i] + 1)
                                 : ((mctr[i] == 0) ? 0 : mctr[i] - 1);
                    if (tk) mtgt[i] = ex_target;
                end
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; ex_valid = 1'b0; ex_is_br = 1'b0; ex_is_jmp = 1'b0; ex_f3 = 3'd0;
        ex_pc = 32'd0; ex_target = 32'd0; ex_ptaken = 1'b0; ex_ptgt = 32'd0;
        br_less = 1'b0; br_equal = 1'b0; stall = 1'b0;
    endtask

    task automatic branch(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptg, input logic lt, input logic eq);
        idle();
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_f3 = f3; ex_pc = pc; ex_target = tgt;
        ex_ptaken = pt; ex_ptgt = ptg; br_less = lt; br_equal = eq;
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    initial begin
        idle();
        if_pc = 32'h100;
        rst   = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // A: post-reset lookup
        idle(); if_pc = 32'h100; step();
        chk("A_pred", pred_taken, 1'b0); chk("A_br", br_cnt, 32'd0); chk("A_misp", misp_cnt, 32'd0);
        tick();
        // B: cold taken BEQ, lookup in the same cycle sees the old (empty) entry
        branch(32'h100, 3'b000, 32'h140, 1'b0, 32'd0, 1'b0, 1'b1); step();
        chk("B_redir", redirect, 1'b1); chk("B_rpc", redirect_pc, 32'h140); chk("B_pred", pred_taken, 1'b0);
        tick();
        idle(); step();
        chk("C_pred", pred_taken, 1'b1); chk("C_tgt", pred_target, 32'h140); chk("C_misp", misp_cnt, 32'd1);
        tick();
        // D: predicted taken, actually not taken
        branch(32'h100, 3'b000, 32'h140, 1'b1, 32'h140, 1'b0, 1'b0); step();
        chk("D_redir", redirect, 1'b1); chk("D_rpc", redirect_pc, 32'h104);
        tick();
        idle(); step(); chk("E_pred", pred_taken, 1'b0); tick();
        // F/G: drive counter to 00 and try to push past it
        branch(32'h100, 3'b000, 32'h140, 1'b0, 32'd0, 1'b0, 1'b0); step();
        chk("F_redir", redirect, 1'b0); tick();
        step(); tick();
        // H: one taken step from 00 must land on 01 (still predicts not taken)
        branch(32'h100, 3'b000, 32'h140, 1'b0, 32'd0, 1'b0, 1'b1); step(); tick();
        idle(); step(); chk("I_pred", pred_taken, 1'b0); tick();
        // J/K: unsigned and signed compares
        branch(32'h208, 3'b110, 32'h300, 1'b0, 32'd0, 1'b1, 1'b0); step();
        chk("J_un", br_un, 1'b1); chk("J_redir", redirect, 1'b1); chk("J_rpc", redirect_pc, 32'h300);
        tick();
        branch(32'h20C, 3'b101, 32'h380, 1'b0, 32'd0, 1'b1, 1'b0); step();
        chk("K_un", br_un, 1'b0); chk("K_redir", redirect, 1'b0);
        tick();
        // L..P: hit rewrites target, then an alias at 0x140 evicts 0x100
        branch(32'h100, 3'b000, 32'h180, 1'b0, 32'd0, 1'b0, 1'b1); step(); tick();
        idle(); step(); chk("M_pred", pred_taken, 1'b1); chk("M_tgt", pred_target, 32'h180); tick();
        branch(32'h140, 3'b001, 32'h1C0, 1'b0, 32'd0, 1'b0, 1'b0); step();
        chk("N_redir", redirect, 1'b1); tick();
        idle(); step(); chk("O_pred", pred_taken, 1'b0); tick();
        if_pc = 32'h140; step(); chk("P_pred", pred_taken, 1'b1); chk("P_tgt", pred_target, 32'h1C0); tick();
        // Q/R: stalled resolution resolves exactly once
        branch(32'h184, 3'b000, 32'h400, 1'b0, 32'd0, 1'b0, 1'b1);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step(); chk("Q_redir", redirect, 1'b0); chk("Q_br", br_cnt, 32'd9); tick();
        end
        stall = 1'b0; step();
        chk("R_redir", redirect, 1'b1); chk("R_rpc", redirect_pc, 32'h400); tick();
        idle(); if_pc = 32'h140; step(); chk("R_br", br_cnt, 32'd10); chk("R_misp", misp_cnt, 32'd7); tick();
        // S: reset in the same cycle as a resolving mispredict
        branch(32'h140, 3'b000, 32'h1C0, 1'b1, 32'h1C0, 1'b0, 1'b0); rst = 1'b1; step();
        chk("S_redir", redirect, 1'b0); chk("S_pred", pred_taken, 1'b0); tick();
        idle(); step();
        chk("S_pred2", pred_taken, 1'b0); chk("S_br", br_cnt, 32'd0); chk("S_misp", misp_cnt, 32'd0);
        tick();

        // Randomized traffic over a small PC space so hits and aliases are frequent.
        for (int n = 0; n < 3000; n++) begin
            int kind;
            idle();
            rst       = ($urandom_range(0, 199) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            kind      = $urandom_range(0, 3);
            ex_valid  = ($urandom_range(0, 7) != 0);
            ex_is_br  = (kind == 1 || kind == 2);
            ex_is_jmp = (kind == 3);
            ex_f3     = 3'($urandom_range(0, 7));
            ex_pc     = 32'($urandom_range(0, 255)) * 32'd4;
            ex_target = 32'($urandom_range(0, 15)) * 32'd64;
            br_less   = 1'($urandom_range(0, 1));
            br_equal  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                ex_ptaken = m_hit(ex_pc) && mctr[m_idx(ex_pc)] >= 2;
                ex_ptgt   = m_hit(ex_pc) ? mtgt[m_idx(ex_pc)] : 32'd0;
            end else begin
                ex_ptaken = 1'($urandom_range(0, 1));
                ex_ptgt   = 32'($urandom_range(0, 15)) * 32'd64;
            end
            if_pc = ($urandom_range(0, 2) == 0) ? ex_pc : 32'($urandom_range(0, 255)) * 32'd4;
            step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
